// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
// WORD_SIZE normally comes from the CPU's global defines; 16 is the fallback.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 15.
   localparam int CNT_W = 4;
endpackage

// File: rtl/mem_grant_sel.sv
// Combinational winner select between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on ties; otherwise data always beats fetch.
module mem_grant_sel
   import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic i_last_gnt,
`endif
   input  logic i_if_req,
   input  logic i_d_req,
   output logic o_gnt_vld,
   output logic o_gnt_id
);

   always_comb begin
      o_gnt_vld = i_if_req | i_d_req;
      o_gnt_id  = REQ_D;
      if (i_if_req && !i_d_req)
         o_gnt_id = REQ_IF;
`ifdef MEM_ARB_RR_EN
      else if (i_if_req && i_d_req)
         o_gnt_id = (i_last_gnt == REQ_D) ? REQ_IF : REQ_D;
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the shared CPU memory port: grant, fixed-latency strobe, one-cycle ack.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of D-over-IF priority.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_W      = `WORD_SIZE,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic              if_ack,
   output logic [WORD_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [WORD_W-1:0] d_rdata,
   output logic              read_m,
   output logic              write_m,
   output logic [WORD_W-1:0] address,
   inout  wire  [WORD_W-1:0] data,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [WORD_W-1:0] r_addr, r_wdata, r_if_rdata, r_d_rdata;
   logic              r_we;
   logic              r_gnt;
   logic              w_gnt_vld, w_gnt_id;

   // r_gnt doubles as the last-grant record for round-robin.
   mem_grant_sel u_sel (
`ifdef MEM_ARB_RR_EN
      .i_last_gnt (r_gnt),
`endif
      .i_if_req   (if_req),
      .i_d_req    (d_req),
      .o_gnt_vld  (w_gnt_vld),
      .o_gnt_id   (w_gnt_id)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_gnt_vld) w_next = ST_ACCESS;
         ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_gnt      <= REQ_IF;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt <= w_gnt_id;
                  r_cnt <= LAT_M1;
                  if (w_gnt_id == REQ_D) begin
                     r_addr  <= d_addr;
                     r_we    <= d_we;
                     r_wdata <= d_wdata;
                  end else begin
                     r_addr  <= if_addr;
                     r_we    <= 1'b0;
                  end
               end
            end
            ST_ACCESS: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0 && !r_we) begin
                  if (r_gnt == REQ_D) r_d_rdata  <= data;
                  else                r_if_rdata <= data;
               end
            end
            default: ;
         endcase
      end
   end

   assign read_m   = (r_state == ST_ACCESS) && !r_we;
   assign write_m  = (r_state == ST_ACCESS) &&  r_we;
   assign address  = r_addr;
   assign busy     = (r_state != ST_IDLE);
   assign if_ack   = (r_state == ST_RESP) && (r_gnt == REQ_IF);
   assign d_ack    = (r_state == ST_RESP) && (r_gnt == REQ_D);
   assign if_rdata = r_if_rdata;
   assign d_rdata  = r_d_rdata;
   assign data     = write_m ? r_wdata : 'z;

endmodule
